kernel_map_vec_pipe: RTL and testbench
======================================

Name: kernel_map_vec_pipe

Overview:
- Vectorised leaf map node for TyBEC-generated pipelines.
- Applies one elementwise binary operation to NLANES lanes of two input streams.
- Result passes through a DEPTH-stage pipeline with a stall-correct valid/ready handshake: valid bits are held, never dropped, under backpressure.
- Replaces single-lane, fixed-add, latency-1 map nodes.

Parameters:
- STREAMW, 32, bit width of one lane.
- NLANES, 2, number of parallel lanes; the bus is packed with lane k at bits [k*STREAMW +: STREAMW].
- DEPTH, 3, number of pipeline stages (latency); legal range 1..16.
- OP, 0, operation: 0 = add, 1 = sub (in1-in2), 2 = mul (low STREAMW bits), 3 = signed max.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- ivalid, in, 1, upstream data valid.
- iready, out, 1, this node can accept data this cycle.
- in1_s0, in, NLANES*STREAMW, operand A, packed lanes.
- in2_s0, in, NLANES*STREAMW, operand B, packed lanes.
- ovalid, out, 1, out1_s0 holds a valid result.
- oready, in, 1, downstream accepts data this cycle.
- out1_s0, out, NLANES*STREAMW, result, packed lanes; registered.

Behaviour:
- Reset is synchronous, active-high on clk.
  - All stage valid bits v[0..DEPTH-1] reset to 0.
  - All stage data registers, including out1_s0, reset to 0.
  - Hence ovalid = 0 and iready = 1 in the cycle after reset.
- Reset mid-operation discards all in-flight data; no partial flush.
- Advance enable: en = oready | ~v[DEPTH-1]. The whole pipeline moves together; there is no bubble collapsing.
- iready = en. This is combinational from oready and v[DEPTH-1]; there is no skid buffer.
- Input accept: xfer_in = ivalid & en.
- When en = 1, all of the following happen at the clock edge:
  - stage 0 data <= f(in1,in2) per lane;
  - v[0] <= ivalid;
  - stage k data/valid <= stage k-1, for k = 1..DEPTH-1.
- When en = 0, all stage data and valid registers hold.
- ovalid = v[DEPTH-1]; out1_s0 = stage DEPTH-1 data.
- Output transfer occurs when ovalid & oready.
- Data registers load on en regardless of ivalid. Stage contents with v = 0 are don't-care and are never flagged valid.
- Latency with no stall: data accepted at edge N appears with ovalid = 1 after edge N+DEPTH-1. For DEPTH = 1 it is visible the cycle after acceptance.
- Throughput is 1 transfer/cycle while oready = 1.
- Stall behaviour:
  - oready = 0 with v[DEPTH-1] = 1: the full pipeline freezes; out1_s0 and ovalid are stable until accepted.
  - oready = 0 with v[DEPTH-1] = 0: the pipeline still advances, filling bubbles.
- Simultaneous output accept and input accept in the same cycle is legal; occupancy is unchanged.
- Arithmetic, per lane, independent and with no inter-lane carry:
  - add/sub wrap modulo 2^STREAMW;
  - mul is unsigned, low STREAMW bits;
  - max compares lanes as two's-complement signed.
- Illegal OP values (>3) produce 0 on the result lanes; handshake behaviour is unaffected.

Optional Feature:
- Macro: KERNEL_MAP_VEC_SAT_EN.
- Defined: OP 0 and 1 saturate as signed two's-complement.
  - Positive overflow -> 2^(STREAMW-1)-1.
  - Negative overflow -> -2^(STREAMW-1).
  - OP 2 and 3 are unchanged; handshake and latency are unchanged.
- Undefined: OP 0 and 1 wrap as specified above; no saturation logic is synthesised.

Test Plan:
- Reset/latency, defaults (OP=0, DEPTH=3, NLANES=2):
  - Stimulus: assert rst 2 cycles; then ivalid=1, oready=1; in1={lane1=5, lane0=7}, in2={lane1=3, lane0=1}.
  - Response: ovalid=0 during and right after reset; out1={8,8} with ovalid=1 exactly 3 edges after acceptance.
- Streaming:
  - Stimulus: 20 back-to-back inputs with lane0=i, lane1=2i and oready=1.
  - Response: 20 outputs in order, consecutive cycles, lane0=2i, lane1=4i.
- Backpressure:
  - Stimulus: pipeline full; drop oready for 4 cycles while ivalid=1.
  - Response: iready=0 and out1_s0/ovalid stable throughout; no loss or duplication across the stall; sequence intact.
- Bubble fill:
  - Stimulus: oready=0 from the start, single input.
  - Response: input still accepted, reaches the output stage after 3 edges, then iready=0 until oready=1.
- Wrap/saturate (OP=0, STREAMW=32):
  - Stimulus: in1=0x7FFFFFFF, in2=1.
  - Response: 0x80000000 without the macro; 0x7FFFFFFF with KERNEL_MAP_VEC_SAT_EN defined.
- Mid-stream reset and modes:
  - Stimulus: rst asserted with 3 items in flight.
  - Response: ovalid=0 next cycle and no stale output later.
  - Also check OP=3 with in1=0xFFFFFFFF (-1) and in2=2 -> 2; and OP=2 with 0x10000 * 0x10000 -> 0.

Source files
------------

// File: rtl/kernel_map_vec_pipe.sv
// Vectorised elementwise binary map node: NLANES lanes, DEPTH-stage stall-correct valid/ready pipeline.
// Optional signed saturation for add/sub is enabled by defining KERNEL_MAP_VEC_SAT_EN.
module kernel_map_vec_pipe #(
    parameter int STREAMW = 32,
    parameter int NLANES  = 2,
    parameter int DEPTH   = 3,
    parameter int OP      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid,
    output logic                        iready,
    input  logic [NLANES*STREAMW-1:0]   in1_s0,
    input  logic [NLANES*STREAMW-1:0]   in2_s0,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [NLANES*STREAMW-1:0]   out1_s0
);

    localparam int BUSW = NLANES * STREAMW;
    localparam int MSB  = STREAMW - 1;

    logic            en;
    logic [BUSW-1:0] result;
    logic [BUSW-1:0] data_reg [DEPTH];
    logic            valid_reg [DEPTH];

    // The whole pipeline moves only when the output stage can empty or is already a bubble.
    assign en     = oready | ~valid_reg[DEPTH-1];
    assign iready = en;
    assign ovalid = valid_reg[DEPTH-1];
    assign out1_s0 = data_reg[DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [STREAMW-1:0] a;
            logic [STREAMW-1:0] b;
            logic [STREAMW-1:0] sum;
            logic [STREAMW-1:0] diff;
            logic [STREAMW-1:0] prod;
            logic [STREAMW-1:0] maxv;
            logic [STREAMW-1:0] add_res;
            logic [STREAMW-1:0] sub_res;
            logic [STREAMW-1:0] res;

            assign a    = in1_s0[gi*STREAMW +: STREAMW];
            assign b    = in2_s0[gi*STREAMW +: STREAMW];
            assign sum  = a + b;
            assign diff = a - b;
            assign prod = a * b;
            assign maxv = ($signed(a) > $signed(b)) ? a : b;

`ifdef KERNEL_MAP_VEC_SAT_EN
            localparam logic [STREAMW-1:0] SMAX = {1'b0, {(STREAMW-1){1'b1}}};
            localparam logic [STREAMW-1:0] SMIN = {1'b1, {(STREAMW-1){1'b0}}};
            logic add_ovf;
            logic sub_ovf;

            // Overflow: operand signs force a result sign that the wrapped value contradicts.
            assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            assign add_res = add_ovf ? (a[MSB] ? SMIN : SMAX) : sum;
            assign sub_res = sub_ovf ? (a[MSB] ? SMIN : SMAX) : diff;
`else
            assign add_res = sum;
            assign sub_res = diff;
`endif

            always_comb begin
                res = '0;
                case (OP)
                    0:       res = add_res;
                    1:       res = sub_res;
                    2:       res = prod;
                    3:       res = maxv;
                    default: res = '0;
                endcase
            end

            assign result[gi*STREAMW +: STREAMW] = res;
        end
    endgenerate

    // Data registers load on every advance; contents behind a cleared valid bit are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_reg[k] <= 1'b0;
                data_reg[k]  <= '0;
            end
        end else if (en) begin
            valid_reg[0] <= ivalid;
            data_reg[0]  <= result;
            for (int k = 1; k < DEPTH; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                data_reg[k]  <= data_reg[k-1];
            end
        end
    end

endmodule

// File: tb/tb_kernel_map_vec_pipe.sv
// Directed bench for kernel_map_vec_pipe: handshake, latency, stalls, reset and every OP mode.
module tb_kernel_map_vec_pipe;

    localparam int W  = 32;
    localparam int NL = 2;
    localparam int BW = W * NL;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ivalid;
    logic          oready;
    logic [BW-1:0] in1;
    logic [BW-1:0] in2;

    logic          iready_add, ovalid_add;
    logic          iready_sub, ovalid_sub;
    logic          iready_mul, ovalid_mul;
    logic          iready_max, ovalid_max;
    logic          iready_bad, ovalid_bad;
    logic [BW-1:0] out_add, out_sub, out_mul, out_max, out_bad;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    kernel_map_vec_pipe #(.STREAMW(W), .NLANES(NL), .DEPTH(D), .OP(0)) dut_add (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_add),
        .in1_s0(in1), .in2_s0(in2), .ovalid(ovalid_add), .oready(oready), .out1_s0(out_add));
    kernel_map_vec_pipe #(.STREAMW(W), .NLANES(NL), .DEPTH(D), .OP(1)) dut_sub (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_sub),
        .in1_s0(in1), .in2_s0(in2), .ovalid(ovalid_sub), .oready(oready), .out1_s0(out_sub));
    kernel_map_vec_pipe #(.STREAMW(W), .NLANES(NL), .DEPTH(D), .OP(2)) dut_mul (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_mul),
        .in1_s0(in1), .in2_s0(in2), .ovalid(ovalid_mul), .oready(oready), .out1_s0(out_mul));
    kernel_map_vec_pipe #(.STREAMW(W), .NLANES(NL), .DEPTH(D), .OP(3)) dut_max (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_max),
        .in1_s0(in1), .in2_s0(in2), .ovalid(ovalid_max), .oready(oready), .out1_s0(out_max));
    kernel_map_vec_pipe #(.STREAMW(W), .NLANES(NL), .DEPTH(1), .OP(5)) dut_bad (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_bad),
        .in1_s0(in1), .in2_s0(in2), .ovalid(ovalid_bad), .oready(oready), .out1_s0(out_bad));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        rst    = 1'b0;
        ivalid = 1'b0;
        oready = 1'b1;
        repeat (D + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ivalid = 1'b0; oready = 1'b1; in1 = '0; in2 = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            compared++;
            if (ovalid_add !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_ovalid cyc%0d: got %b expected 0", c, ovalid_add);
            end
            compared++;
            if (out_add !== 64'h0) begin
                mismatched++;
                $display("FAIL reset_out cyc%0d: got %h expected 0", c, out_add);
            end
        end
        rst = 1'b0;
        #1;
        compared++;
        if (iready_add !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_iready: got %b expected 1", iready_add);
        end
        $display("reset: done");
    endtask

    task automatic test_latency();
        in1 = {32'd5, 32'd7}; in2 = {32'd3, 32'd1}; ivalid = 1'b1; oready = 1'b1;
        tick();
        ivalid = 1'b0;
        for (int e = 0; e < 2; e++) begin
            compared++;
            if (ovalid_add !== 1'b0) begin
                mismatched++;
                $display("FAIL latency_early edge%0d: got %b expected 0", e, ovalid_add);
            end
            tick();
        end
        compared++;
        if (ovalid_add !== 1'b1) begin
            mismatched++;
            $display("FAIL latency_ovalid: got %b expected 1", ovalid_add);
        end
        compared++;
        if (out_add !== {32'd8, 32'd8}) begin
            mismatched++;
            $display("FAIL latency_data: got %h expected %h", out_add, {32'd8, 32'd8});
        end
        $display("latency: out=%h", out_add);
        flush();
    endtask

    task automatic test_streaming();
        int idx = 0;
        int first_c = -1;
        int last_c = -1;
        oready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 20) begin
                ivalid = 1'b1;
                in1 = {32'(2 * c), 32'(c)};
                in2 = {32'(2 * c), 32'(c)};
            end else begin
                ivalid = 1'b0;
            end
            tick();
            if (ovalid_add === 1'b1) begin
                compared++;
                if (out_add !== {32'(4 * idx), 32'(2 * idx)}) begin
                    mismatched++;
                    $display("FAIL stream_data item%0d: got %h expected %h",
                             idx, out_add, {32'(4 * idx), 32'(2 * idx)});
                end
                $display("stream: item %0d out=%h", idx, out_add);
                if (first_c < 0) first_c = c;
                last_c = c;
                idx++;
            end
        end
        compared++;
        if (idx != 20) begin
            mismatched++;
            $display("FAIL stream_count: got %0d expected 20", idx);
        end
        compared++;
        if (last_c - first_c != 19) begin
            mismatched++;
            $display("FAIL stream_span: got %0d expected 19", last_c - first_c);
        end
        flush();
    endtask

    task automatic test_backpressure();
        int p = 0;
        int q = 0;
        logic          acc_in;
        logic [BW-1:0] held_out;
        logic          held_v;
        held_out = '0;
        held_v   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            oready = !(c >= 6 && c < 10);
            ivalid = (p < 10);
            in1 = {32'(p + 1000), 32'(p)};
            in2 = {32'd1, 32'(p)};
            #1;
            if (c == 6) begin
                held_out = out_add;
                held_v   = ovalid_add;
                compared++;
                if (ovalid_add !== 1'b1) begin
                    mismatched++;
                    $display("FAIL bp_full: got %b expected 1", ovalid_add);
                end
            end
            if (c >= 6 && c < 10) begin
                compared++;
                if (iready_add !== 1'b0) begin
                    mismatched++;
                    $display("FAIL bp_iready cyc%0d: got %b expected 0", c, iready_add);
                end
                if (c > 6) begin
                    compared++;
                    if (out_add !== held_out || ovalid_add !== held_v) begin
                        mismatched++;
                        $display("FAIL bp_hold cyc%0d: got %b/%h expected %b/%h",
                                 c, ovalid_add, out_add, held_v, held_out);
                    end
                end
            end
            acc_in = ivalid && iready_add;
            if (ovalid_add === 1'b1 && oready) begin
                compared++;
                if (out_add !== {32'(q + 1001), 32'(2 * q)}) begin
                    mismatched++;
                    $display("FAIL bp_data item%0d: got %h expected %h",
                             q, out_add, {32'(q + 1001), 32'(2 * q)});
                end
                $display("backpressure: item %0d out=%h", q, out_add);
                q++;
            end
            @(posedge clk);
            if (acc_in) p++;
            #1;
        end
        compared++;
        if (q != 10) begin
            mismatched++;
            $display("FAIL bp_count: got %0d expected 10", q);
        end
        flush();
    endtask

    task automatic test_bubble_fill();
        oready = 1'b0; ivalid = 1'b1;
        in1 = {32'd20, 32'd10}; in2 = {32'd2, 32'd1};
        #1;
        compared++;
        if (iready_add !== 1'b1) begin
            mismatched++;
            $display("FAIL bubble_accept: got %b expected 1", iready_add);
        end
        tick();
        ivalid = 1'b0;
        for (int e = 0; e < 2; e++) begin
            compared++;
            if (ovalid_add !== 1'b0) begin
                mismatched++;
                $display("FAIL bubble_early edge%0d: got %b expected 0", e, ovalid_add);
            end
            tick();
        end
        for (int h = 0; h < 3; h++) begin
            compared++;
            if (ovalid_add !== 1'b1 || out_add !== {32'd22, 32'd11} || iready_add !== 1'b0) begin
                mismatched++;
                $display("FAIL bubble_hold step%0d: got v=%b r=%b %h expected v=1 r=0 %h",
                         h, ovalid_add, iready_add, out_add, {32'd22, 32'd11});
            end
            tick();
        end
        oready = 1'b1;
        #1;
        compared++;
        if (iready_add !== 1'b1) begin
            mismatched++;
            $display("FAIL bubble_release: got %b expected 1", iready_add);
        end
        tick();
        compared++;
        if (ovalid_add !== 1'b0) begin
            mismatched++;
            $display("FAIL bubble_drain: got %b expected 0", ovalid_add);
        end
        $display("bubble_fill: done");
        flush();
    endtask

    task automatic test_wrap();
        logic [BW-1:0] exp_v;
`ifdef KERNEL_MAP_VEC_SAT_EN
        exp_v = {32'h80000000, 32'h7FFFFFFF};
`else
        exp_v = {32'h7FFFFFFF, 32'h80000000};
`endif
        in1 = {32'h80000000, 32'h7FFFFFFF}; in2 = {32'hFFFFFFFF, 32'h00000001};
        ivalid = 1'b1; oready = 1'b1;
        tick();
        ivalid = 1'b0;
        tick();
        tick();
        compared++;
        if (ovalid_add !== 1'b1 || out_add !== exp_v) begin
            mismatched++;
            $display("FAIL wrap_sat: got v=%b %h expected v=1 %h", ovalid_add, out_add, exp_v);
        end
        $display("wrap: out=%h", out_add);
        flush();
    endtask

    task automatic test_mid_reset();
        oready = 1'b0; ivalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in1 = {32'(i), 32'(i + 50)}; in2 = {32'd1, 32'd1};
            tick();
        end
        compared++;
        if (ovalid_add !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_inflight: got %b expected 1", ovalid_add);
        end
        rst = 1'b1; ivalid = 1'b0;
        tick();
        compared++;
        if (ovalid_add !== 1'b0 || out_add !== 64'h0) begin
            mismatched++;
            $display("FAIL midrst_clear: got v=%b %h expected v=0 0", ovalid_add, out_add);
        end
        rst = 1'b0; oready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (ovalid_add !== 1'b0) begin
                mismatched++;
                $display("FAIL midrst_stale cyc%0d: got %b expected 0", c, ovalid_add);
            end
        end
        $display("mid_reset: done");
        flush();
    endtask

    task automatic test_modes();
        in1 = {32'h00010000, 32'hFFFFFFFF}; in2 = {32'h00010000, 32'h00000002};
        ivalid = 1'b1; oready = 1'b1;
        tick();
        ivalid = 1'b0;
        compared++;
        if (ovalid_bad !== 1'b1 || out_bad !== 64'h0) begin
            mismatched++;
            $display("FAIL illegal_op_depth1: got v=%b %h expected v=1 0", ovalid_bad, out_bad);
        end
        tick();
        tick();
        compared++;
        if (ovalid_max !== 1'b1 || out_max !== {32'h00010000, 32'h00000002}) begin
            mismatched++;
            $display("FAIL op_max: got v=%b %h expected v=1 %h",
                     ovalid_max, out_max, {32'h00010000, 32'h00000002});
        end
        compared++;
        if (ovalid_mul !== 1'b1 || out_mul !== {32'h00000000, 32'hFFFFFFFE}) begin
            mismatched++;
            $display("FAIL op_mul: got v=%b %h expected v=1 %h",
                     ovalid_mul, out_mul, {32'h00000000, 32'hFFFFFFFE});
        end
        compared++;
        if (ovalid_sub !== 1'b1 || out_sub !== {32'h00000000, 32'hFFFFFFFD}) begin
            mismatched++;
            $display("FAIL op_sub: got v=%b %h expected v=1 %h",
                     ovalid_sub, out_sub, {32'h00000000, 32'hFFFFFFFD});
        end
        compared++;
        if (ovalid_bad !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_op_drain: got %b expected 0", ovalid_bad);
        end
        $display("modes: max=%h mul=%h sub=%h", out_max, out_mul, out_sub);
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_bubble_fill();
        test_wrap();
        test_mid_reset();
        test_modes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
